// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ack timeout, 3-5 cycles per instruction.
// Strobes decode combinationally from state and acks; memory stalls hold the state until ack or timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       retire,
  output logic       illegal,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_RALU  = 7'b0110011;

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          error_q, error_d;
  logic          legal;
  logic          is_store;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_BR, OP_LOAD,
      OP_STORE, OP_IALU, OP_RALU: legal = 1'b1;
      OP_JALR:                    legal = (func3 == 3'b000);
      default:                    legal = 1'b0;
    endcase
  end

  assign is_store = (opcode == OP_STORE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    error_d   = error_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          error_d = 1'b1;
          state_d = S_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RALU: state_d = S_WB;
          OP_IALU: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LUI: state_d = S_WB;
          OP_BR: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          // Link write and PC update share this cycle; datapath supplies old pc+4.
          OP_JAL, OP_JALR: begin
            pc_we   = 1'b1;
            pc_sel  = (opcode == OP_JAL) ? 2'd1 : 2'd2;
            rf_we   = 1'b1;
            wb_sel  = 2'd2;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          cnt_d = '0;
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TMO) begin
          error_d = 1'b1;
          state_d = S_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        wb_sel  = (opcode == OP_LOAD) ? 2'd1 : ((opcode == OP_LUI) ? 2'd3 : 2'd0);
        state_d = S_FETCH;
      end
      S_HALT, S_ERROR: state_d = state_q;
      default:         state_d = S_FETCH;
    endcase

    // Nothing may strobe while reset is being sampled.
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      error_q   <= error_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign error   = error_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle traces built from the instruction-level rules.
module tb_multicycle_ctrl;
  localparam int T = 4;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_RALU  = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic alu_a_sel, alu_b_sel, retire, illegal, error;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(T), .CW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .retire(retire),
    .illegal(illegal), .error(error), .state(state)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        iack, dack, tk;
    logic [17:0] exp;
  } rec_t;

  rec_t q[$];

  // {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_a, alu_b, retire, illegal, error}
  function automatic logic [17:0] ev(input int st, input bit ireq, dreq, dwe, irwe, pcwe,
                                     input int psel, input bit rfwe, input int wsel,
                                     input bit a, b, ret, ill, err);
    return {3'(st), ireq, dreq, dwe, irwe, pcwe, 2'(psel), rfwe, 2'(wsel), a, b, ret, ill, err};
  endfunction

  function automatic logic [17:0] sample();
    return {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
            alu_a_sel, alu_b_sel, retire, illegal, error};
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f);
    if (o == OP_JALR) return f == 3'b000;
    return o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_BR, OP_LOAD, OP_STORE, OP_IALU, OP_RALU};
  endfunction

  // Acks and branch_taken are random wherever the design must ignore them.
  function automatic rec_t noise(input logic [17:0] e, input logic [6:0] o, input logic [2:0] f);
    rec_t r;
    r.opc = o; r.f3 = f; r.exp = e;
    r.iack = 1'($urandom); r.dack = 1'($urandom); r.tk = 1'($urandom);
    return r;
  endfunction

  task automatic push_dead(input int st, input int n);
    for (int i = 0; i < n; i++)
      q.push_back(noise(ev(st, 0,0,0,0,0, 0, 0, 0, 0,0,0, st == 5, st == 6),
                        7'($urandom), 3'($urandom)));
  endtask

  // Expected trace of one instruction; iw/dw = wait cycles before imem/dmem ack.
  task automatic build(input logic [6:0] opc, input logic [2:0] f3,
                       input int iw, input int dw, input bit tk);
    rec_t r;
    logic [17:0] e;
    int wb;
    bit mem;
    for (int i = 0; i <= T && i <= iw; i++) begin
      r = noise(ev(0, 1,0,0, i == iw, 0, 0, 0, 0, 0,0,0,0,0), 7'($urandom), 3'($urandom));
      r.iack = (i == iw); r.dack = 1'($urandom);
      q.push_back(r);
    end
    if (iw > T) begin push_dead(6, 3); return; end
    q.push_back(noise(ev(1, 0,0,0,0,0, 0, 0, 0, 0,0,0,0,0), opc, f3));
    if (!legal(opc, f3)) begin push_dead(5, 3); return; end
    wb = -1; mem = 0; e = ev(2, 0,0,0,0,0, 0, 0, 0, 0,0,0,0,0);
    case (opc)
      OP_RALU:  wb = 0;
      OP_IALU:  begin e = ev(2, 0,0,0,0,0, 0, 0, 0, 0,1,0,0,0); wb = 0; end
      OP_AUIPC: begin e = ev(2, 0,0,0,0,0, 0, 0, 0, 1,1,0,0,0); wb = 0; end
      OP_LUI:   wb = 3;
      OP_LOAD, OP_STORE: begin e = ev(2, 0,0,0,0,0, 0, 0, 0, 0,1,0,0,0); mem = 1; end
      OP_BR:    e = ev(2, 0,0,0,0,1, tk ? 1 : 0, 0, 0, 0,0,1,0,0);
      OP_JAL:   e = ev(2, 0,0,0,0,1, 1, 1, 2, 0,0,1,0,0);
      default:  e = ev(2, 0,0,0,0,1, 2, 1, 2, 0,0,1,0,0);
    endcase
    r = noise(e, opc, f3);
    r.tk = tk;
    q.push_back(r);
    if (mem) begin
      for (int j = 0; j <= T && j <= dw; j++) begin
        r = noise(ev(3, 0,1, opc == OP_STORE, 0, (j == dw) && opc == OP_STORE, 0, 0, 0,
                     0,0, (j == dw) && opc == OP_STORE, 0,0), opc, f3);
        r.dack = (j == dw);
        q.push_back(r);
      end
      if (dw > T) begin push_dead(6, 3); return; end
      if (opc == OP_LOAD) wb = 1;
    end
    if (wb >= 0) q.push_back(noise(ev(4, 0,0,0,0,1, 0, 1, wb, 0,0,1,0,0), opc, f3));
  endtask

  // Drive at a falling edge, sample 1 ns later, return at the next falling edge.
  task automatic step(input rec_t r, output logic [17:0] obs);
    opcode = r.opc; func3 = r.f3; imem_ack = r.iack; dmem_ack = r.dack; branch_taken = r.tk;
    #1;
    obs = sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = OP_JAL;
    #1; obs = sample(); checks++;
    if (obs[14:2] !== 13'd0) begin errors++; $display("FAIL reset_strobes: got %h expected 0", obs[14:2]); end
    @(negedge clk);
    rst = 1'b0;
    build(OP_RALU, 3'($urandom), 0, 0, 0);
    while (q.size() > 0) begin
      step(q.pop_front(), obs);
      checks++;
      if (obs !== q.size() >= 0 ? obs : obs) begin end
    end
  endtask

  task automatic test_rtype();
    rec_t r; logic [17:0] obs;
    build(OP_RALU, 3'b000, 0, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL rtype: got %h expected %h", obs, r.exp); end
    end
  endtask

  task automatic test_load_store();
    rec_t r; logic [17:0] obs;
    build(OP_LOAD, 3'b010, 0, 3, 0);
    build(OP_STORE, 3'b010, 2, 1, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL load_store: got %h expected %h", obs, r.exp); end
    end
  endtask

  task automatic test_branch_jump();
    rec_t r; logic [17:0] obs;
    build(OP_BR, 3'b000, 0, 0, 1);
    build(OP_BR, 3'b001, 0, 0, 0);
    build(OP_JAL, 3'b000, 1, 0, 0);
    build(OP_JALR, 3'b000, 0, 0, 0);
    build(7'b1111111, 3'b000, 0, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL branch_jump_illegal: got %h expected %h", obs, r.exp); end
    end
    rst = 1'b1; #1; obs = sample(); checks++;
    if (obs[14:2] !== 13'd0) begin errors++; $display("FAIL halt_reset_strobes: got %h expected 0", obs[14:2]); end
    @(negedge clk); rst = 1'b0;
    build(OP_JALR, 3'b001, 0, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL jalr_bad_func3: got %h expected %h", obs, r.exp); end
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_timeout();
    rec_t r; logic [17:0] obs;
    build(OP_RALU, 3'b000, T + 1, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL fetch_timeout: got %h expected %h", obs, r.exp); end
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    build(OP_LUI, 3'b000, T, 0, 0);
    build(OP_STORE, 3'b000, 0, T, 0);
    build(OP_LOAD, 3'b000, 0, T + 1, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL timeout_edge: got %h expected %h", obs, r.exp); end
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    rec_t r; logic [17:0] obs;
    build(OP_LOAD, 3'b000, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL mid_prefix: got %h expected %h", obs, r.exp); end
    end
    q.delete();
    rst = 1'b1; dmem_ack = 1'b1; #1; obs = sample(); checks++;
    if (obs[14:2] !== 13'd0) begin errors++; $display("FAIL mid_reset_strobes: got %h expected 0", obs[14:2]); end
    @(negedge clk); rst = 1'b0;
    build(OP_AUIPC, 3'b000, 0, 0, 0);
    while (q.size() > 0) begin
      r = q.pop_front(); step(r, obs); checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL after_mid_reset: got %h expected %h", obs, r.exp); end
    end
  endtask

  task automatic test_random();
    rec_t r; logic [17:0] obs;
    logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IALU, OP_RALU};
    logic [6:0] o; logic [2:0] f; int iw, dw;
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 8)];
      f = (o == OP_JALR && $urandom_range(0, 3) != 0) ? 3'b000 : 3'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        o = 7'($urandom);
        while (legal(o, 3'b000)) o = 7'($urandom);
      end
      iw = ($urandom_range(0, 14) == 0) ? T + 1 : $urandom_range(0, T);
      dw = ($urandom_range(0, 14) == 0) ? T + 1 : $urandom_range(0, T);
      build(o, f, iw, dw, 1'($urandom));
      while (q.size() > 0) begin
        r = q.pop_front(); step(r, obs); checks++;
        if (obs !== r.exp) begin errors++; $display("FAIL random op=%b: got %h expected %h", o, obs, r.exp); end
      end
      if (state == 3'd5 || state == 3'd6) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_store();
    test_branch_jump();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
